// File: rtl/fm_pkg.sv
// Shared derivations and FSM encodings for the feature-map DDR write-back path.
package fm_pkg;

  function automatic int unsigned word_w(input int unsigned lanes, input int unsigned lane_w);
    return lanes * lane_w;
  endfunction

  function automatic int unsigned buf_w(input int unsigned ddr_w, input int unsigned wrd_w);
    return ddr_w + wrd_w;
  endfunction

  function automatic int unsigned fill_w(input int unsigned bw);
    return $clog2(bw + 1);
  endfunction

  localparam int unsigned DEF_WORD_W = word_w(18, 8);
  localparam int unsigned DEF_BUF_W  = buf_w(256, DEF_WORD_W);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/fm_ddr_writeback_gearbox.sv
// Bit-level gearbox: packs WORD_W-bit words LSB-first into DDR_WIDTH-bit beats.
module fm_gearbox
  import fm_pkg::*;
#(
  parameter int unsigned WORD_W    = 144,
  parameter int unsigned DDR_WIDTH = 256,
  localparam int unsigned BUF_W    = buf_w(DDR_WIDTH, WORD_W),
  localparam int unsigned FILL_W   = fill_w(BUF_W)
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic [WORD_W-1:0]    push_data,
  input  logic                 flush,
  input  logic                 ready,
  output logic [FILL_W-1:0]    fill,
  output logic [FILL_W-1:0]    fill_next,
  output logic                 valid,
  output logic [DDR_WIDTH-1:0] data
);

  localparam logic [FILL_W-1:0] DDR_FILL  = FILL_W'(DDR_WIDTH);
  localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);

  logic [BUF_W-1:0]  sreg_q, sreg_d, shifted, word_ext;
  logic [FILL_W-1:0] fill_q, fill_d, drop, base;
  logic              pop;

  always_comb begin
    valid    = (fill_q >= DDR_FILL) || (flush && (fill_q != '0));
    pop      = valid && ready;
    drop     = '0;
    shifted  = sreg_q;
    base     = fill_q;
    word_ext = BUF_W'(push_data);
    if (pop) begin
      drop    = (fill_q < DDR_FILL) ? fill_q : DDR_FILL;
      shifted = sreg_q >> DDR_WIDTH;
      base    = fill_q - drop;
    end
    // Bits above fill are always zero, so OR-ing the new word in is safe.
    sreg_d = push ? (shifted | (word_ext << base)) : shifted;
    fill_d = fill_q - drop + (push ? WORD_FILL : '0);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sreg_q <= '0;
      fill_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      fill_q <= fill_d;
    end
  end

  assign fill      = fill_q;
  assign fill_next = fill_d;
  assign data      = sreg_q[DDR_WIDTH-1:0];

endmodule

// File: rtl/fm_ddr_writeback.sv
// Drains a run of feature-map words from on-chip memory into dense DDR beats.
module fm_ddr_writeback
  import fm_pkg::*;
#(
  parameter int unsigned CONV_OUT_NUM = 18,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FM_MEM_DEPTH = 13,
  parameter int unsigned DDR_WIDTH    = 256
) (
  input  logic                                 sys_clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [FM_MEM_DEPTH-1:0]              base_addr,
  input  logic [FM_MEM_DEPTH:0]                word_cnt,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 fm_rd_en,
  output logic [FM_MEM_DEPTH-1:0]              fm_rd_addr,
  input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0]   fm_rd_data,
  output logic [DDR_WIDTH-1:0]                 DDR_out_data,
  output logic                                 DDR_out_valid,
  input  logic                                 DDR_out_ready
);

  localparam int unsigned WORD_W = word_w(CONV_OUT_NUM, DATA_WIDTH);
  localparam int unsigned FILL_W = fill_w(buf_w(DDR_WIDTH, WORD_W));
  localparam logic [FILL_W:0] DDR_LIM  = (FILL_W + 1)'(DDR_WIDTH);
  localparam logic [FILL_W:0] WORD_LIM = (FILL_W + 1)'(WORD_W);

  logic [1:0]              state_q, state_d;
  logic [FM_MEM_DEPTH-1:0] addr_q;
  logic [FM_MEM_DEPTH:0]   rem_q;
  logic                    in_flight_q;
  logic [FILL_W-1:0]       fill, fill_next;
  logic [FILL_W:0]         pending;
  logic                    flush;

  // Count the in-flight word so the buffer can never overflow.
  assign pending    = {1'b0, fill} + (in_flight_q ? WORD_LIM : '0);
  assign fm_rd_en   = (state_q == StRun) && (rem_q != '0) && (pending < DDR_LIM);
  assign fm_rd_addr = addr_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign flush      = (state_q == StFlush);

  // Exits look at next-cycle fill so done lands one cycle after the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if ((rem_q == '0) && ({1'b0, fill_next} < DDR_LIM)) begin
          state_d = (fill_next == '0) ? StDone : StFlush;
        end
      end
      StFlush: if (fill_next == '0) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= fm_rd_en;
      if ((state_q == StIdle) && start) begin
        addr_q <= base_addr;
        rem_q  <= word_cnt;
      end else if (fm_rd_en) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  fm_gearbox #(
    .WORD_W    (WORD_W),
    .DDR_WIDTH (DDR_WIDTH)
  ) u_gearbox (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .push      (in_flight_q),
    .push_data (fm_rd_data),
    .flush     (flush),
    .ready     (DDR_out_ready),
    .fill      (fill),
    .fill_next (fill_next),
    .valid     (DDR_out_valid),
    .data      (DDR_out_data)
  );

endmodule

// File: tb/tb_fm_ddr_writeback.sv
// Scoreboard bench for fm_ddr_writeback: memory model, bit-stream reference, beat monitor.
module tb_fm_ddr_writeback;

  localparam int W  = 144;
  localparam int DW = 256;
  localparam int AW = 13;

  logic           sys_clk = 1'b0;
  logic           rstn;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [AW:0]    word_cnt;
  logic           busy, done, fm_rd_en;
  logic [AW-1:0]  fm_rd_addr;
  logic [W-1:0]   fm_rd_data;
  logic [DW-1:0]  DDR_out_data;
  logic           DDR_out_valid;
  logic           DDR_out_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads_seen, beats_seen, done_seen, last_hs, max_fill;
  bit rnd_ready = 1'b0;
  logic [DW-1:0] first_beat, last_beat;
  logic [DW-1:0] exp_beats[$];
  logic [AW-1:0] exp_addr[$];

  fm_ddr_writeback dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .start         (start),
    .base_addr     (base_addr),
    .word_cnt      (word_cnt),
    .busy          (busy),
    .done          (done),
    .fm_rd_en      (fm_rd_en),
    .fm_rd_addr    (fm_rd_addr),
    .fm_rd_data    (fm_rd_data),
    .DDR_out_data  (DDR_out_data),
    .DDR_out_valid (DDR_out_valid),
    .DDR_out_ready (DDR_out_ready)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] gen_word(input logic [AW-1:0] a);
    logic [W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*16 +: 16] = {3'(k), a} ^ 16'h5A3C ^ 16'(k * 16'h0F11);
    return w;
  endfunction

  // Memory model: data valid one cycle after the read strobe.
  always @(posedge sys_clk) if (fm_rd_en) fm_rd_data <= gen_word(fm_rd_addr);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference packing: beat j bit i is stream bit j*256+i, stream = words back to back.
  task automatic push_run(input logic [AW-1:0] base, input int cnt);
    int nbits;
    int nbeats;
    logic [W-1:0] w;
    logic [DW-1:0] b;
    nbits  = cnt * W;
    nbeats = (nbits + DW - 1) / DW;
    for (int j = 0; j < nbeats; j++) begin
      b = '0;
      for (int i = 0; i < DW; i++) begin
        if (j * DW + i < nbits) begin
          w = gen_word(AW'(base + AW'((j * DW + i) / W)));
          b[i] = w[(j * DW + i) % W];
        end
      end
      exp_beats.push_back(b);
    end
    for (int i = 0; i < cnt; i++) exp_addr.push_back(AW'(base + AW'(i)));
  endtask

  // Monitor: pops the scoreboard on every address strobe and beat handshake.
  initial begin
    bit prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    logic [AW-1:0] ea;
    prev_stall = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (int'(dut.u_gearbox.fill) > max_fill) max_fill = int'(dut.u_gearbox.fill);
        if (prev_stall) begin
          chk("stall_valid", DW'(DDR_out_valid), DW'(1));
          chk("stall_data", DDR_out_data, prev_data);
        end
        prev_stall = DDR_out_valid && !DDR_out_ready;
        prev_data  = DDR_out_data;
        if (fm_rd_en) begin
          reads_seen++;
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got addr %0h expected no read", fm_rd_addr);
          end else begin
            ea = exp_addr.pop_front();
            chk("rd_addr", DW'(fm_rd_addr), DW'(ea));
          end
        end
        if (DDR_out_valid && DDR_out_ready) begin
          if (beats_seen == 0) first_beat = DDR_out_data;
          last_beat = DDR_out_data;
          beats_seen++;
          last_hs = cyc;
          if (exp_beats.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: got %0h expected no beat", DDR_out_data);
          end else begin
            e = exp_beats.pop_front();
            chk("beat_data", DDR_out_data, e);
          end
        end
        if (done) begin
          done_seen++;
          if (beats_seen > 0) chk("done_after_hs", DW'(cyc), DW'(last_hs + 1));
        end
      end
    end
  end

  initial begin
    DDR_out_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1 DDR_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Returns in cycle t+1 after the accepted start.
  task automatic start_run(input logic [AW-1:0] base, input int cnt);
    push_run(base, cnt);
    reads_seen = 0; beats_seen = 0; done_seen = 0; max_fill = 0;
    @(negedge sys_clk);
    base_addr = base; word_cnt = (AW + 1)'(cnt); start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("busy_t1", DW'(busy), DW'(1));
  endtask

  task automatic wait_done(input int cnt, input int nbeats);
    int i;
    for (i = 0; i < 3000 && done_seen == 0; i++) @(posedge sys_clk);
    if (done_seen == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
    @(negedge sys_clk);
    chk("busy_after_done", DW'(busy), DW'(0));
    chk("read_count", DW'(reads_seen), DW'(cnt));
    chk("beat_count", DW'(beats_seen), DW'(nbeats));
    chk("done_count", DW'(done_seen), DW'(1));
    chk("beats_left", DW'(exp_beats.size()), DW'(0));
    chk("addrs_left", DW'(exp_addr.size()), DW'(0));
  endtask

  initial begin
    logic [W-1:0] w0, w1, w15;
    int i;
    rstn = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
    @(negedge sys_clk);
    chk("reset_ctrl", DW'({busy, done, fm_rd_en, DDR_out_valid}), DW'(0));
    chk("reset_data", DDR_out_data, '0);
    chk("reset_addr", DW'(fm_rd_addr), DW'(0));
    @(negedge sys_clk);
    rstn = 1'b1;
    @(negedge sys_clk);

    // Exact multiple: 16 words, 9 beats, first beat at t+4.
    start_run(13'h100, 16);
    chk("rd_en_t1", DW'(fm_rd_en), DW'(1));
    @(negedge sys_clk);
    chk("rd_en_t2", DW'(fm_rd_en), DW'(1));
    @(negedge sys_clk);
    chk("valid_t3", DW'(DDR_out_valid), DW'(0));
    @(negedge sys_clk);
    chk("valid_t4", DW'(DDR_out_valid), DW'(1));
    wait_done(16, 9);
    w0 = gen_word(13'h100); w1 = gen_word(13'h101); w15 = gen_word(13'h10F);
    chk("beat0_pack", first_beat, {w1[111:0], w0});
    chk("beat8_top", DW'(last_beat[255:112]), DW'(w15));

    // Single word: padded beat.
    start_run(13'h0ABC, 1);
    wait_done(1, 1);
    w0 = gen_word(13'h0ABC);
    chk("single_beat", last_beat, {112'b0, w0});

    // Zero words: done at t+2, start during busy ignored.
    reads_seen = 0; beats_seen = 0; done_seen = 0;
    @(negedge sys_clk);
    base_addr = 13'h0040; word_cnt = '0; start = 1'b1;
    @(negedge sys_clk);
    chk("zero_busy_t1", DW'(busy), DW'(1));
    chk("zero_rd_t1", DW'(fm_rd_en), DW'(0));
    @(negedge sys_clk);
    chk("zero_done_t2", DW'(done), DW'(1));
    start = 1'b0;
    @(negedge sys_clk);
    chk("zero_busy_t3", DW'(busy), DW'(0));
    repeat (3) @(negedge sys_clk);
    chk("zero_ignored", DW'(busy), DW'(0));
    chk("zero_reads", DW'(reads_seen), DW'(0));
    chk("zero_beats", DW'(beats_seen), DW'(0));
    chk("zero_done_cnt", DW'(done_seen), DW'(1));

    // Address wrap past top of memory.
    start_run(13'h1FFE, 4);
    wait_done(4, 3);
    w1 = gen_word(13'h0001);
    chk("wrap_last", last_beat, {192'b0, w1[143:80]});

    // Random backpressure.
    rnd_ready = 1'b1;
    start_run(13'h0777, 37);
    wait_done(37, 21);
    rnd_ready = 1'b0;
    chk("fill_bound", DW'(max_fill <= 400), DW'(1));

    // Reset during beat 3, then a clean run.
    start_run(13'h0200, 16);
    for (i = 0; i < 200 && beats_seen < 3; i++) @(posedge sys_clk);
    chk("reach_beat3", DW'(beats_seen), DW'(3));
    #2 rstn = 1'b0;
    #1;
    chk("midrst_ctrl", DW'({busy, done, fm_rd_en, DDR_out_valid}), DW'(0));
    chk("midrst_data", DDR_out_data, '0);
    chk("midrst_addr", DW'(fm_rd_addr), DW'(0));
    exp_beats.delete();
    exp_addr.delete();
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    @(negedge sys_clk);
    start_run(13'h0300, 16);
    wait_done(16, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
